// File: rtl/paddle_emu.sv
// rtl/paddle_emu.sv - paddle emulation from a PS/2 mouse or an analog stick
// The mouse accumulates clamped deltas into saturating positions; any analog activity takes over.
module paddle_emu #(
  parameter int OUT_W      = 8,
  parameter int DELTA_MAX  = 10,
  parameter int SENS_SHIFT = 1,
  parameter int DEADZONE   = 0
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic [24:0]      ps2_mouse,
  input  logic [15:0]      joya,
  input  logic [1:0]       joy_btn,
  input  logic             center,
  output logic [OUT_W-1:0] paddle_x,
  output logic [OUT_W-1:0] paddle_y,
  output logic [1:0]       btn,
  output logic             src_mouse,
  output logic             upd
);

  // Two extra bits so acc + delta can never overflow before saturation.
  localparam int DW = OUT_W + 2;
  localparam logic signed [DW-1:0] ACC_MAX = DW'((1 <<< (OUT_W - 1)) - 1);
  localparam logic signed [DW-1:0] ACC_MIN = -ACC_MAX - DW'(1);
  localparam logic signed [DW-1:0] DMAX    = DW'(DELTA_MAX);
  localparam logic [8:0]           DZ      = 9'(DEADZONE);

  typedef enum logic {ST_ANALOG, ST_MOUSE} state_t;

  state_t                 state;
  logic                   strobe_q;
  logic signed [OUT_W:0]  acc_x;
  logic signed [OUT_W:0]  acc_y;
  logic                   mouse_evt;
  logic                   analog_act;
  logic signed [DW-1:0]   delta_x;
  logic signed [DW-1:0]   delta_y;
  logic signed [OUT_W:0]  base_x;
  logic signed [OUT_W:0]  base_y;
  logic signed [OUT_W:0]  nxt_x;
  logic signed [OUT_W:0]  nxt_y;
  logic signed [OUT_W-1:0] ana_x;
  logic signed [OUT_W-1:0] ana_y;

  function automatic logic signed [DW-1:0] clamp_delta(input logic sign_b, input logic [7:0] mag);
    logic signed [8:0]    raw;
    logic signed [DW-1:0] d;
    raw = {sign_b, mag};
    d   = DW'(raw >>> SENS_SHIFT);
    if (d > DMAX)
      d = DMAX;
    else if (d < -DMAX)
      d = -DMAX;
    return d;
  endfunction

  function automatic logic signed [OUT_W:0] sat_add(input logic signed [OUT_W:0] base,
                                                     input logic signed [DW-1:0]  d);
    logic signed [DW-1:0] s;
    s = DW'(base) + d;
    if (s > ACC_MAX)
      s = ACC_MAX;
    else if (s < ACC_MIN)
      s = ACC_MIN;
    return s[OUT_W:0];
  endfunction

  // -128 must count as magnitude 128, hence the 9-bit magnitude.
  function automatic logic beyond_deadzone(input logic [7:0] v);
    logic [8:0] mag;
    mag = v[7] ? (9'd256 - {1'b0, v}) : {1'b0, v};
    return mag > DZ;
  endfunction

  assign mouse_evt  = ps2_mouse[24] ^ strobe_q;
  assign analog_act = beyond_deadzone(joya[7:0]) | beyond_deadzone(joya[15:8]);
  assign delta_x    = clamp_delta(ps2_mouse[4], ps2_mouse[15:8]);
  assign delta_y    = clamp_delta(ps2_mouse[5], ps2_mouse[23:16]);
  assign ana_x      = OUT_W'(signed'(joya[7:0])) <<< (OUT_W - 8);
  assign ana_y      = OUT_W'(signed'(joya[15:8])) <<< (OUT_W - 8);

  always_comb begin
    base_x = '0;
    base_y = '0;
    if (state == ST_MOUSE && !center) begin
      base_x = acc_x;
      base_y = acc_y;
    end
    nxt_x = mouse_evt ? sat_add(base_x, delta_x) : base_x;
    nxt_y = mouse_evt ? sat_add(base_y, delta_y) : base_y;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state     <= ST_ANALOG;
      strobe_q  <= ps2_mouse[24];
      acc_x     <= '0;
      acc_y     <= '0;
      paddle_x  <= '0;
      paddle_y  <= '0;
      btn       <= 2'b00;
      src_mouse <= 1'b0;
      upd       <= 1'b0;
    end else begin
      strobe_q <= ps2_mouse[24];
      upd      <= 1'b0;
      if (analog_act) begin
        state     <= ST_ANALOG;
        acc_x     <= '0;
        acc_y     <= '0;
        paddle_x  <= ana_x;
        paddle_y  <= ana_y;
        btn       <= joy_btn;
        src_mouse <= 1'b0;
      end else if (state == ST_ANALOG && !mouse_evt) begin
        paddle_x  <= ana_x;
        paddle_y  <= ana_y;
        btn       <= joy_btn;
        src_mouse <= 1'b0;
      end else begin
        state     <= ST_MOUSE;
        acc_x     <= nxt_x;
        acc_y     <= nxt_y;
        paddle_x  <= nxt_x[OUT_W-1:0];
        paddle_y  <= nxt_y[OUT_W-1:0];
        btn       <= ps2_mouse[1:0];
        src_mouse <= 1'b1;
        upd       <= mouse_evt;
      end
    end
  end

endmodule

// File: tb/tb_paddle_emu.sv
// tb/tb_paddle_emu.sv - self-checking bench for paddle_emu
// Directed scenarios plus randomized traffic against an integer reference model.
module tb_paddle_emu;

  logic               clk_sys = 1'b0;
  logic               reset_n;
  logic [24:0]        ps2_mouse;
  logic [15:0]        joya;
  logic [1:0]         joy_btn;
  logic               center;
  logic signed [7:0]  paddle_x, paddle_y;
  logic [1:0]         btn;
  logic               src_mouse, upd;
  logic [9:0]         px10, py10;
  logic [1:0]         btn10;
  logic               src10, upd10;

  int total = 0;
  int bad   = 0;

  bit       m_mouse, m_upd, m_prev;
  int       m_ax, m_ay, m_px, m_py, m_px10;
  logic [1:0] m_btn;

  paddle_emu u_dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_mouse(ps2_mouse), .joya(joya),
    .joy_btn(joy_btn), .center(center), .paddle_x(paddle_x), .paddle_y(paddle_y),
    .btn(btn), .src_mouse(src_mouse), .upd(upd)
  );

  paddle_emu #(.OUT_W(10)) u_dut10 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_mouse(ps2_mouse), .joya(joya),
    .joy_btn(joy_btn), .center(center), .paddle_x(px10), .paddle_y(py10),
    .btn(btn10), .src_mouse(src10), .upd(upd10)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic int sbyte(input logic [7:0] b);
    return b[7] ? int'(b) - 256 : int'(b);
  endfunction

  function automatic int mdelta(input bit s, input logic [7:0] b);
    int r;
    r = s ? int'(b) - 256 : int'(b);
    r = r >>> 1;
    if (r > 10) r = 10;
    if (r < -10) r = -10;
    return r;
  endfunction

  function automatic int sat8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic model_step();
    bit ev, act;
    int x, y, bx, by;
    if (!reset_n) begin
      m_mouse = 0; m_ax = 0; m_ay = 0; m_px = 0; m_py = 0; m_px10 = 0;
      m_btn = 2'b00; m_upd = 0; m_prev = ps2_mouse[24];
    end else begin
      ev = (ps2_mouse[24] != m_prev);
      m_prev = ps2_mouse[24];
      x = sbyte(joya[7:0]);
      y = sbyte(joya[15:8]);
      act = (x != 0) || (y != 0);
      m_upd = 0;
      if (act || (!m_mouse && !ev)) begin
        m_mouse = 0; m_ax = 0; m_ay = 0;
        m_px = x; m_py = y; m_px10 = x * 4; m_btn = joy_btn;
      end else begin
        bx = (m_mouse && !center) ? m_ax : 0;
        by = (m_mouse && !center) ? m_ay : 0;
        if (ev) begin
          bx = sat8(bx + mdelta(ps2_mouse[4], ps2_mouse[15:8]));
          by = sat8(by + mdelta(ps2_mouse[5], ps2_mouse[23:16]));
        end
        m_mouse = 1; m_ax = bx; m_ay = by; m_px = bx; m_py = by;
        m_btn = ps2_mouse[1:0]; m_upd = ev;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk_sys);
    model_step();
    #1;
  endtask

  task automatic set_evt(input logic [7:0] dx, input bit dxs, input logic [7:0] dy,
                         input bit dys, input logic [1:0] bt);
    ps2_mouse = {~ps2_mouse[24], dy, dx, 2'b00, dys, dxs, 2'b00, bt};
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; joya = 16'h0; center = 1'b0; joy_btn = 2'b00;
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ps2_mouse[24] = 1'b1;
    cyc();
    ps2_mouse[24] = 1'b0;
    joy_btn = 2'b11;
    cyc();
    total++; if (paddle_x !== 8'sd0) begin bad++; $display("FAIL reset_px got=%0d exp=0", paddle_x); end
    total++; if (paddle_y !== 8'sd0) begin bad++; $display("FAIL reset_py got=%0d exp=0", paddle_y); end
    total++; if (btn !== 2'b00) begin bad++; $display("FAIL reset_btn got=%0d exp=0", btn); end
    total++; if (src_mouse !== 1'b0) begin bad++; $display("FAIL reset_src got=%0d exp=0", src_mouse); end
    total++; if (upd !== 1'b0) begin bad++; $display("FAIL reset_upd got=%0d exp=0", upd); end
    reset_n = 1'b1;
    joy_btn = 2'b00;
    cyc();
    total++; if (upd !== 1'b0 || src_mouse !== 1'b0) begin bad++; $display("FAIL reset_release got=%0d%0d exp=00", upd, src_mouse); end
  endtask

  task automatic test_first_event();
    apply_reset();
    set_evt(8'h28, 0, 8'h00, 0, 2'b01);
    cyc();
    total++; if (paddle_x !== 8'sd10) begin bad++; $display("FAIL first_px got=%0d exp=10", paddle_x); end
    total++; if (src_mouse !== 1'b1) begin bad++; $display("FAIL first_src got=%0d exp=1", src_mouse); end
    total++; if (upd !== 1'b1) begin bad++; $display("FAIL first_upd got=%0d exp=1", upd); end
    total++; if (btn !== 2'b01) begin bad++; $display("FAIL first_btn got=%0d exp=1", btn); end
    cyc();
    total++; if (upd !== 1'b0 || paddle_x !== 8'sd10) begin bad++; $display("FAIL first_hold got upd=%0d px=%0d exp upd=0 px=10", upd, paddle_x); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 15; i++) begin
      set_evt(8'h28, 0, 8'h00, 0, 2'b00);
      cyc();
    end
    total++; if (paddle_x !== 8'sd127) begin bad++; $display("FAIL sat_px got=%0d exp=127", paddle_x); end
    set_evt(8'hB0, 1, 8'h00, 0, 2'b00);
    cyc();
    total++; if (paddle_x !== 8'sd117) begin bad++; $display("FAIL sat_neg_px got=%0d exp=117", paddle_x); end
  endtask

  task automatic test_analog_override();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      set_evt(8'h28, 0, 8'h00, 0, 2'b00);
      cyc();
    end
    total++; if (paddle_x !== 8'sd50) begin bad++; $display("FAIL ovr_acc got=%0d exp=50", paddle_x); end
    joya = 16'h0005;
    cyc();
    total++; if (src_mouse !== 1'b0 || paddle_x !== 8'sd5) begin bad++; $display("FAIL ovr_analog got src=%0d px=%0d exp src=0 px=5", src_mouse, paddle_x); end
    joya = 16'h0000;
    set_evt(8'h04, 0, 8'h00, 0, 2'b00);
    cyc();
    total++; if (src_mouse !== 1'b1 || paddle_x !== 8'sd2) begin bad++; $display("FAIL ovr_back got src=%0d px=%0d exp src=1 px=2", src_mouse, paddle_x); end
  endtask

  task automatic test_collision();
    apply_reset();
    set_evt(8'h28, 0, 8'h28, 0, 2'b00);
    joya = 16'h0100;
    cyc();
    total++; if (src_mouse !== 1'b0 || upd !== 1'b0) begin bad++; $display("FAIL coll_src_upd got=%0d%0d exp=00", src_mouse, upd); end
    total++; if (paddle_y !== 8'sd1) begin bad++; $display("FAIL coll_py got=%0d exp=1", paddle_y); end
    joya = 16'h0000;
    cyc();
    total++; if (src_mouse !== 1'b0) begin bad++; $display("FAIL coll_discard got=%0d exp=0", src_mouse); end
  endtask

  task automatic test_center();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      set_evt(8'h28, 0, 8'h00, 0, 2'b00);
      cyc();
    end
    total++; if (paddle_x !== 8'sd30) begin bad++; $display("FAIL ctr_acc got=%0d exp=30", paddle_x); end
    center = 1'b1;
    cyc();
    total++; if (paddle_x !== 8'sd0) begin bad++; $display("FAIL ctr_alone got=%0d exp=0", paddle_x); end
    for (int i = 0; i < 2; i++) begin
      set_evt(8'h28, 0, 8'h00, 0, 2'b00);
      center = 1'b0;
      cyc();
    end
    set_evt(8'h14, 0, 8'h00, 0, 2'b00);
    center = 1'b1;
    cyc();
    center = 1'b0;
    total++; if (paddle_x !== 8'sd10) begin bad++; $display("FAIL ctr_evt got=%0d exp=10", paddle_x); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      set_evt(8'h28, 0, 8'h00, 0, 2'b00);
      cyc();
    end
    total++; if (paddle_x !== 8'sd100) begin bad++; $display("FAIL mid_acc got=%0d exp=100", paddle_x); end
    reset_n = 1'b0;
    set_evt(8'h28, 0, 8'h00, 0, 2'b11);
    cyc();
    reset_n = 1'b1;
    total++; if ({paddle_x, paddle_y, btn, src_mouse, upd} !== 20'h0) begin bad++; $display("FAIL mid_reset got px=%0d src=%0d upd=%0d exp all 0", paddle_x, src_mouse, upd); end
    cyc();
    total++; if (upd !== 1'b0 || paddle_x !== 8'sd0 || src_mouse !== 1'b0) begin bad++; $display("FAIL mid_release got upd=%0d px=%0d exp 0", upd, paddle_x); end
    joya = 16'h007F;
    cyc();
    total++; if (px10 !== 10'h1FC) begin bad++; $display("FAIL w10_px got=%0h exp=1fc", px10); end
    total++; if (paddle_x !== 8'sd127) begin bad++; $display("FAIL w8_px got=%0d exp=127", paddle_x); end
    joya = 16'h0000;
    cyc();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset_n = ($urandom_range(0, 60) != 0);
      if ($urandom_range(0, 1) == 1)
        set_evt(8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 2'($urandom));
      case ($urandom_range(0, 9))
        0:       joya = 16'($urandom);
        1:       joya = {8'h00, 8'($urandom_range(0, 2))};
        2:       joya = 16'h8000;
        default: joya = 16'h0000;
      endcase
      joy_btn = 2'($urandom);
      center  = ($urandom_range(0, 7) == 0);
      cyc();
      total++; if (int'(paddle_x) !== m_px) begin bad++; $display("FAIL rnd_px cyc=%0d got=%0d exp=%0d", i, paddle_x, m_px); end
      total++; if (int'(paddle_y) !== m_py) begin bad++; $display("FAIL rnd_py cyc=%0d got=%0d exp=%0d", i, paddle_y, m_py); end
      total++; if (btn !== m_btn) begin bad++; $display("FAIL rnd_btn cyc=%0d got=%0d exp=%0d", i, btn, m_btn); end
      total++; if (src_mouse !== m_mouse) begin bad++; $display("FAIL rnd_src cyc=%0d got=%0d exp=%0d", i, src_mouse, m_mouse); end
      total++; if (upd !== m_upd) begin bad++; $display("FAIL rnd_upd cyc=%0d got=%0d exp=%0d", i, upd, m_upd); end
      if (!m_mouse) begin
        total++; if (int'($signed(px10)) !== m_px10) begin bad++; $display("FAIL rnd_px10 cyc=%0d got=%0d exp=%0d", i, $signed(px10), m_px10); end
      end
    end
    reset_n = 1'b1;
    center  = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; ps2_mouse = '0; joya = 16'h0; joy_btn = 2'b00; center = 1'b0;
    m_mouse = 0; m_upd = 0; m_prev = 0; m_ax = 0; m_ay = 0; m_px = 0; m_py = 0; m_px10 = 0; m_btn = 2'b00;
    test_reset();
    test_first_event();
    test_saturate();
    test_analog_override();
    test_collision();
    test_center();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
